// File: rtl/alu_issue_stage.sv
// Two-entry (main + skid) issue buffer between decode and the ALU, with operand forwarding at capture and while held.
// Latency: a beat accepted at edge N is presented on out_* right after edge N when it lands in main; zero-bubble when out_ready=1.
// Backpressure: in_ready is registered and drops only when both entries are full; out_* come from the main entry only.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic [63:0] in_rs1_val,
    input  logic [63:0] in_rs2_val,
    input  logic [63:0] in_imm,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [3:0]  in_alu_ctrl,
    input  logic        in_a_pc,
    input  logic        in_b_imm,
    input  logic        in_reg_write,
    input  logic        exm_wen,
    input  logic [4:0]  exm_rd,
    input  logic [63:0] exm_data,
    input  logic        mwb_wen,
    input  logic [4:0]  mwb_rd,
    input  logic [63:0] mwb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_ctrl,
    output logic [63:0] out_alu_a,
    output logic [63:0] out_alu_b,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic [63:0] out_pc,
    output logic [63:0] out_store_data
);

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1_val;
        logic [63:0] rs2_val;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_ctrl;
        logic        a_pc;
        logic        b_imm;
        logic        reg_write;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d;
    entry_t in_cap, main_snp, skid_snp;
    logic   in_ready_q, out_valid_q;
    logic   in_fire, out_fire;

    // EX/MEM wins over MEM/WB; x0 is never forwarded.
    function automatic logic [63:0] fwd(
        input logic [4:0]  idx,
        input logic [63:0] dflt,
        input logic        e_wen,
        input logic [4:0]  e_rd,
        input logic [63:0] e_data,
        input logic        m_wen,
        input logic [4:0]  m_rd,
        input logic [63:0] m_data
    );
        if (idx != 5'd0 && e_wen && e_rd == idx)
            return e_data;
        else if (idx != 5'd0 && m_wen && m_rd == idx)
            return m_data;
        else
            return dflt;
    endfunction

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid_q & out_ready;

    always_comb begin
        in_cap.pc        = in_pc;
        in_cap.rs1_val   = fwd(in_rs1, in_rs1_val, exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data);
        in_cap.rs2_val   = fwd(in_rs2, in_rs2_val, exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data);
        in_cap.imm       = in_imm;
        in_cap.rs1       = in_rs1;
        in_cap.rs2       = in_rs2;
        in_cap.rd        = in_rd;
        in_cap.alu_ctrl  = in_alu_ctrl;
        in_cap.a_pc      = in_a_pc;
        in_cap.b_imm     = in_b_imm;
        in_cap.reg_write = in_reg_write;

        main_snp         = main_q;
        main_snp.rs1_val = fwd(main_q.rs1, main_q.rs1_val, exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data);
        main_snp.rs2_val = fwd(main_q.rs2, main_q.rs2_val, exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data);

        skid_snp         = skid_q;
        skid_snp.rs1_val = fwd(skid_q.rs1, skid_q.rs1_val, exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data);
        skid_snp.rs2_val = fwd(skid_q.rs2, skid_q.rs2_val, exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data);
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_cap;
                end
            end
            ONE: begin
                main_d = main_snp;
                if (in_fire && out_fire) begin
                    main_d = in_cap;
                end else if (in_fire) begin
                    state_d = TWO;
                    skid_d  = in_cap;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                main_d = main_snp;
                skid_d = skid_snp;
                // Promote the snooped skid copy so a same-cycle writeback is not lost.
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_snp;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush)
            state_d = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
            main_q      <= main_d;
            skid_q      <= skid_d;
        end
    end

    assign out_alu_ctrl   = main_q.alu_ctrl;
    assign out_alu_a      = main_q.a_pc ? main_q.pc : main_q.rs1_val;
    assign out_alu_b      = main_q.b_imm ? main_q.imm : main_q.rs2_val;
    assign out_store_data = main_q.rs2_val;
    assign out_rd         = main_q.rd;
    assign out_reg_write  = main_q.reg_write;
    assign out_pc         = main_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed beats push expected ALU-side results, a monitor pops on each out-fire.
module tb_alu_issue_stage;

    logic        clk, rst_n, flush;
    logic        in_valid, in_ready;
    logic [63:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [3:0]  in_alu_ctrl;
    logic        in_a_pc, in_b_imm, in_reg_write;
    logic        exm_wen, mwb_wen;
    logic [4:0]  exm_rd, mwb_rd;
    logic [63:0] exm_data, mwb_data;
    logic        out_valid, out_ready;
    logic [3:0]  out_alu_ctrl;
    logic [63:0] out_alu_a, out_alu_b, out_pc, out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_ctrl(in_alu_ctrl),
        .in_a_pc(in_a_pc), .in_b_imm(in_b_imm), .in_reg_write(in_reg_write),
        .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_ctrl(out_alu_ctrl), .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_pc(out_pc),
        .out_store_data(out_store_data)
    );

    typedef struct packed {
        logic [63:0] pc, rs1v, rs2v, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  ctrl;
        logic        a_pc, b_imm, rw;
    } beat_t;

    typedef struct packed {
        logic [63:0] a, b, st, pc;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic beat_t mkb(input logic [63:0] pc, input logic [4:0] rs1, input logic [63:0] rs1v,
                                  input logic [4:0] rs2, input logic [63:0] rs2v, input logic [63:0] imm,
                                  input logic [4:0] rd, input logic [3:0] ctrl,
                                  input logic a_pc, input logic b_imm, input logic rw);
        beat_t b;
        b.pc = pc; b.rs1 = rs1; b.rs1v = rs1v; b.rs2 = rs2; b.rs2v = rs2v; b.imm = imm;
        b.rd = rd; b.ctrl = ctrl; b.a_pc = a_pc; b.b_imm = b_imm; b.rw = rw;
        return b;
    endfunction

    function automatic exp_t mke(input logic [63:0] a, input logic [63:0] b, input logic [63:0] st,
                                 input beat_t bt);
        exp_t e;
        e.a = a; e.b = b; e.st = st; e.pc = bt.pc; e.ctrl = bt.ctrl; e.rd = bt.rd; e.rw = bt.rw;
        return e;
    endfunction

    task automatic apply(input beat_t b);
        in_pc = b.pc; in_rs1 = b.rs1; in_rs1_val = b.rs1v; in_rs2 = b.rs2; in_rs2_val = b.rs2v;
        in_imm = b.imm; in_rd = b.rd; in_alu_ctrl = b.ctrl; in_a_pc = b.a_pc; in_b_imm = b.b_imm;
        in_reg_write = b.rw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers a beat until accepted (bounded); returns the number of edges waited.
    task automatic send(input beat_t b, input exp_t e, input bit do_push, output int waits);
        logic rdy;
        apply(b);
        in_valid = 1'b1;
        waits = 0;
        rdy = 1'b0;
        while (!rdy && waits < 50) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            waits++;
        end
        if (rdy && do_push) sb.push_back(e);
        if (!rdy) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !flush && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", {out_alu_ctrl, out_pc}, 0);
                end else begin
                    e = sb.pop_front();
                    check("alu_a", out_alu_a, e.a);
                    check("alu_b", out_alu_b, e.b);
                    check("store_data", out_store_data, e.st);
                    check("sideband", {out_alu_ctrl, out_rd, out_reg_write, out_pc},
                          {e.ctrl, e.rd, e.rw, e.pc});
                end
            end
        end
    end

    initial begin
        beat_t b1, b2, b3, ba, bb, bc, f1, f2, f3, s1, d, j, k, l;
        exp_t  nx;
        int    w;

        nx = '0;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        apply('0);
        exm_wen = 1'b0; exm_rd = '0; exm_data = '0;
        mwb_wen = 1'b0; mwb_rd = '0; mwb_data = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_ctrl", out_alu_ctrl, 0);
        check("rst_reg_write", out_reg_write, 0);
        check("rst_alu_a", out_alu_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Pass-through and zero-bubble streaming
        out_ready = 1'b1;
        b1 = mkb(64'h100, 5'd1, 64'd5, 5'd2, 64'd7, 64'h55, 5'd4, 4'b0010, 1'b0, 1'b0, 1'b1);
        b2 = mkb(64'h104, 5'd6, 64'h30, 5'd7, 64'h40, 64'd8, 5'd5, 4'b0000, 1'b1, 1'b1, 1'b1);
        b3 = mkb(64'h108, 5'd0, 64'h9, 5'd0, '1, 64'd0, 5'd0, 4'b1111, 1'b0, 1'b0, 1'b0);
        send(b1, mke(64'd5, 64'd7, 64'd7, b1), 1, w);
        check("pt_out_valid", out_valid, 1);
        send(b2, mke(64'h104, 64'd8, 64'h40, b2), 1, w);
        check("zero_bubble_b2", w, 1);
        send(b3, mke(64'h9, '1, '1, b3), 1, w);
        check("zero_bubble_b3", w, 1);
        repeat (3) step();

        // Backpressure: two accepted, third held off
        out_ready = 1'b0;
        ba = mkb(64'h10, 5'd1, 64'hA1, 5'd2, 64'hA2, 64'd0, 5'd8, 4'd8, 1'b0, 1'b0, 1'b1);
        bb = mkb(64'h14, 5'd1, 64'hB1, 5'd2, 64'hB2, 64'd0, 5'd9, 4'd9, 1'b0, 1'b0, 1'b1);
        bc = mkb(64'h18, 5'd1, 64'hC1, 5'd2, 64'hC2, 64'd0, 5'd10, 4'd10, 1'b0, 1'b0, 1'b1);
        send(ba, mke(64'hA1, 64'hA2, 64'hA2, ba), 1, w);
        send(bb, mke(64'hB1, 64'hB2, 64'hB2, bb), 1, w);
        check("bp_in_ready_full", in_ready, 0);
        apply(bc);
        in_valid = 1'b1;
        repeat (3) step();
        check("bp_still_full", in_ready, 0);
        check("bp_head_is_a", out_pc, 64'h10);
        out_ready = 1'b1;
        send(bc, mke(64'hC1, 64'hC2, 64'hC2, bc), 1, w);
        repeat (4) step();

        // Capture forwarding priority and x0 exclusion
        exm_wen = 1'b1; exm_rd = 5'd3; exm_data = 64'hAA;
        mwb_wen = 1'b1; mwb_rd = 5'd3; mwb_data = 64'hBB;
        f1 = mkb(64'h200, 5'd3, 64'h11, 5'd5, 64'h22, 64'd0, 5'd1, 4'd1, 1'b0, 1'b0, 1'b1);
        send(f1, mke(64'hAA, 64'h22, 64'h22, f1), 1, w);
        exm_wen = 1'b0;
        f2 = mkb(64'h204, 5'd3, 64'h11, 5'd0, 64'h44, 64'd0, 5'd2, 4'd1, 1'b0, 1'b0, 1'b1);
        send(f2, mke(64'hBB, 64'h44, 64'h44, f2), 1, w);
        exm_wen = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0;
        f3 = mkb(64'h208, 5'd0, 64'h77, 5'd0, 64'h66, 64'd0, 5'd3, 4'd1, 1'b0, 1'b0, 1'b1);
        send(f3, mke(64'h77, 64'h66, 64'h66, f3), 1, w);
        exm_wen = 1'b0; mwb_wen = 1'b0;
        repeat (3) step();

        // Hold snoop while stalled
        out_ready = 1'b0;
        s1 = mkb(64'h300, 5'd1, 64'h10, 5'd9, 64'h99, 64'd16, 5'd2, 4'd3, 1'b0, 1'b1, 1'b1);
        send(s1, mke(64'h10, 64'd16, 64'h1234, s1), 1, w);
        step();
        check("snoop_before", out_store_data, 64'h99);
        mwb_wen = 1'b1; mwb_rd = 5'd9; mwb_data = 64'h1234;
        step();
        check("snoop_store", out_store_data, 64'h1234);
        check("snoop_alu_b", out_alu_b, 64'd16);
        out_ready = 1'b1;
        step();
        mwb_wen = 1'b0;
        out_ready = 1'b0;
        repeat (2) step();

        // Flush from TWO, then from ONE with same-cycle in-fire and out-fire
        d = mkb(64'hDEAD, 5'd1, 64'hD1, 5'd2, 64'hD2, 64'd0, 5'd11, 4'd11, 1'b0, 1'b0, 1'b1);
        send(d, nx, 0, w);
        send(d, nx, 0, w);
        check("fl_pre_full", in_ready, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_two_out_valid", out_valid, 0);
        check("fl_two_in_ready", in_ready, 1);
        send(d, nx, 0, w);
        apply(d);
        in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("fl_one_out_valid", out_valid, 0);
        check("fl_one_in_ready", in_ready, 1);
        repeat (3) step();
        check("fl_stays_empty", out_valid, 0);
        j = mkb(64'h400, 5'd2, 64'h21, 5'd3, 64'h31, 64'd4, 5'd7, 4'd5, 1'b0, 1'b1, 1'b1);
        send(j, mke(64'h21, 64'd4, 64'h31, j), 1, w);
        repeat (3) step();

        // Async reset while full, then accept on first edge after release
        out_ready = 1'b0;
        k = mkb(64'h600, 5'd1, 64'h61, 5'd2, 64'h62, 64'd0, 5'd12, 4'd7, 1'b0, 1'b0, 1'b1);
        send(k, nx, 0, w);
        send(k, nx, 0, w);
        check("ar_pre_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_in_ready", in_ready, 1);
        check("ar_alu_a", out_alu_a, 0);
        check("ar_ctrl", out_alu_ctrl, 0);
        l = mkb(64'h500, 5'd4, 64'hABCD, 5'd5, 64'h1, 64'h20, 5'd3, 4'd6, 1'b1, 1'b0, 1'b0);
        apply(l);
        in_valid = 1'b1;
        #1 rst_n = 1'b1;
        step();
        in_valid = 1'b0;
        check("ar_first_accept", out_valid, 1);
        sb.push_back(mke(64'h500, 64'd1, 64'd1, l));
        out_ready = 1'b1;
        repeat (5) step();

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end

endmodule
